// File: rtl/ccg_bist_collector_if.sv
// Handshake/data bundle between the BIST collector and its controller/CUT side.
// The slave modport is the collector; the master modport drives start, golden and the CUT response.
interface ccg_bist_collector_if #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 12,
    parameter int unsigned SIG_W = 16
);
    logic             start;
    logic [SIG_W-1:0] golden_sig;
    logic [N_IN-1:0]  x_out;
    logic [N_OUT-1:0] resp_in;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic             pass;

    modport master (
        output start, golden_sig, resp_in,
        input  x_out, busy, done, signature, pass
    );

    modport slave (
        input  start, golden_sig, resp_in,
        output x_out, busy, done, signature, pass
    );
endinterface

// File: rtl/ccg_bist_collector.sv
// Exhaustive-sweep BIST wrapper: drives 2^N_IN patterns into a combinational CUT,
// registers its outputs, folds them into a Galois MISR and compares against a golden signature.
module ccg_bist_collector #(
    parameter int unsigned         N_IN  = 2,
    parameter int unsigned         N_OUT = 12,
    parameter int unsigned         SIG_W = 16,
    parameter logic [SIG_W-1:0]    POLY  = 16'h1021,
    parameter logic [SIG_W-1:0]    SEED  = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ccg_bist_collector_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [N_IN-1:0] LastPat = '1;

    state_e           r_state, w_state_nxt;
    logic [N_IN-1:0]  r_x, w_x_nxt;
    logic [N_OUT-1:0] r_resp, w_resp_nxt;
    logic             r_v, w_v_nxt;
    logic [SIG_W-1:0] r_sig, w_sig_nxt;
    logic             r_done, w_done_nxt;
    logic             r_pass, w_pass_nxt;
    logic [SIG_W-1:0] w_resp_ext;
    logic [SIG_W-1:0] w_misr;

    assign w_resp_ext = SIG_W'(r_resp);
    assign w_misr     = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_resp_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_x     <= '0;
            r_resp  <= '0;
            r_v     <= 1'b0;
            r_sig   <= SEED;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_resp  <= w_resp_nxt;
            r_v     <= w_v_nxt;
            r_sig   <= w_sig_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_resp_nxt  = r_resp;
        w_v_nxt     = r_v;
        w_sig_nxt   = r_sig;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_state_nxt = StRun;
                    w_x_nxt     = '0;
                    w_sig_nxt   = SEED;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_v_nxt     = 1'b0;
                end
            end
            StRun: begin
                w_resp_nxt = bus.resp_in;
                w_v_nxt    = 1'b1;
                // The first RUN cycle has nothing captured yet, so it must not fold.
                if (r_v) begin
                    w_sig_nxt = w_misr;
                end
                if (r_x == LastPat) begin
                    w_state_nxt = StFlush;
                end else begin
                    w_x_nxt = r_x + N_IN'(1);
                end
            end
            StFlush: begin
                w_sig_nxt   = w_misr;
                w_pass_nxt  = (w_misr == bus.golden_sig);
                w_done_nxt  = 1'b1;
                w_v_nxt     = 1'b0;
                w_state_nxt = StDone;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.x_out     = r_x;
    assign bus.busy      = (r_state == StRun) || (r_state == StFlush);
    assign bus.done      = r_done;
    assign bus.signature = r_sig;
    assign bus.pass      = r_pass;
endmodule

// File: tb/tb_ccg_bist_collector.sv
// Scoreboard bench for ccg_bist_collector: default, SEED=0 loopback and N_IN=1 instances.
module tb_ccg_bist_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  xs[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          busy_cnt;
    int          resp_mode = 0;
    logic [15:0] last_sig;

    ccg_bist_collector_if #(.N_IN(2), .N_OUT(12), .SIG_W(16)) bif ();
    ccg_bist_collector_if #(.N_IN(2), .N_OUT(12), .SIG_W(16)) sif ();
    ccg_bist_collector_if #(.N_IN(1), .N_OUT(12), .SIG_W(16)) nif ();

    assign bif.resp_in = (resp_mode == 0) ? 12'h000 : {bif.x_out, 8'h3C, ~bif.x_out};
    assign sif.resp_in = {10'b0, sif.x_out};
    assign nif.resp_in = 12'h000;

    ccg_bist_collector #(.N_IN(2), .N_OUT(12), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bif));
    ccg_bist_collector #(.N_IN(2), .N_OUT(12), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000))
        u_dut_s0 (.clk(clk), .rst_n(rst_n), .bus(sif));
    ccg_bist_collector #(.N_IN(1), .N_OUT(12), .SIG_W(16), .POLY(16'h1021), .SEED(16'hFFFF))
        u_dut_n1 (.clk(clk), .rst_n(rst_n), .bus(nif));

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
        logic [15:0] fb;
        fb = s[15] ? 16'h1021 : 16'h0000;
        return ({s[14:0], 1'b0} ^ fb) ^ r;
    endfunction

    function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n_in,
                                              input int mode);
        logic [15:0] s;
        logic [1:0]  x;
        logic [15:0] r;
        s = seed;
        for (int p = 0; p < (1 << n_in); p++) begin
            x = p[1:0];
            if (mode == 0)      r = 16'h0000;
            else if (mode == 1) r = {4'b0, x, 8'h3C, ~x};
            else                r = {14'b0, x};
            s = misr_step(s, r);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on the default instance; optional extra start pulses in RUN cycles 2 and 3.
    task automatic sweep_main(input bit disturb, input logic [15:0] golden, input bit chk_edge);
        exp_t e;
        exp_t got;
        bif.golden_sig = golden;
        e.sig  = model_sig(16'hFFFF, 2, resp_mode);
        e.pass = (e.sig == golden);
        exp_q.push_back(e);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        if (chk_edge) begin
            n_chk++;
            if (bif.done !== 1'b0 || bif.busy !== 1'b1 || bif.signature !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL restart_edge: done=%b busy=%b sig=%h, required done=0 busy=1 sig=ffff",
                         bif.done, bif.busy, bif.signature);
            end
        end
        busy_cnt = 0;
        xs.delete();
        for (int c = 0; c < 40 && bif.done !== 1'b1; c++) begin
            if (bif.busy === 1'b1) busy_cnt++;
            xs.push_back(bif.x_out);
            bif.start = disturb && (c == 1 || c == 2);
            tick();
            bif.start = 1'b0;
        end
        got = exp_q.pop_front();
        n_chk++;
        if (bif.done !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_timeout: done=%b, required 1 within 40 cycles", bif.done);
        end else if (bif.signature !== got.sig || bif.pass !== got.pass) begin
            n_fail++;
            $display("FAIL sweep_result: sig=%h pass=%b, required sig=%h pass=%b",
                     bif.signature, bif.pass, got.sig, got.pass);
        end
        last_sig = bif.signature;
    endtask

    task automatic test_reset();
        bif.start = 1'b0; bif.golden_sig = 16'h0;
        sif.start = 1'b0; sif.golden_sig = 16'h0;
        nif.start = 1'b0; nif.golden_sig = 16'h0;
        #12;
        n_chk++;
        if (bif.x_out !== 2'd0 || bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.pass !== 1'b0 ||
            bif.signature !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_values: x=%0d busy=%b done=%b pass=%b sig=%h, required 0 0 0 0 ffff",
                     bif.x_out, bif.busy, bif.done, bif.pass, bif.signature);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_resp();
        logic [1:0] exp_x[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        resp_mode = 0;
        sweep_main(1'b0, 16'h0E1F, 1'b0);
        n_chk++;
        if (busy_cnt != 5) begin
            n_fail++;
            $display("FAIL zero_busy_cycles: got %0d, required 5", busy_cnt);
        end
        n_chk++;
        if (last_sig !== 16'h0E1F || bif.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_golden: sig=%h pass=%b, required 0e1f 1", last_sig, bif.pass);
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (xs.size() != 5 || xs[i] !== exp_x[i]) begin
                n_fail++;
                $display("FAIL x_sequence[%0d]: size=%0d, required %0d", i, xs.size(), exp_x[i]);
            end
        end
    endtask

    task automatic test_pattern();
        logic [15:0] m;
        resp_mode = 1;
        m = model_sig(16'hFFFF, 2, 1);
        sweep_main(1'b0, m, 1'b0);
        sweep_main(1'b0, m ^ 16'h0001, 1'b0);
        n_chk++;
        if (bif.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_wrong_golden: pass=%b, required 0", bif.pass);
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] ref_sig;
        resp_mode = 1;
        sweep_main(1'b0, 16'h1234, 1'b0);
        ref_sig = last_sig;
        sweep_main(1'b1, 16'h1234, 1'b0);
        n_chk++;
        if (busy_cnt != 5 || last_sig !== ref_sig) begin
            n_fail++;
            $display("FAIL start_ignored: busy=%0d sig=%h, required 5 %h", busy_cnt, last_sig, ref_sig);
        end
    endtask

    task automatic test_reset_abort();
        resp_mode = 1;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bif.busy !== 1'b0 || bif.x_out !== 2'd0 || bif.signature !== 16'hFFFF ||
            bif.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b x=%0d sig=%h done=%b, required 0 0 ffff 0",
                     bif.busy, bif.x_out, bif.signature, bif.done);
        end
        #2 rst_n = 1'b1;
        tick();
        sweep_main(1'b0, model_sig(16'hFFFF, 2, 1), 1'b0);
        n_chk++;
        if (busy_cnt != 5 || bif.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL after_abort: busy=%0d pass=%b, required 5 1", busy_cnt, bif.pass);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] first;
        resp_mode = 1;
        sweep_main(1'b0, 16'h0000, 1'b0);
        first = last_sig;
        sweep_main(1'b0, 16'h0000, 1'b1);
        n_chk++;
        if (last_sig !== first) begin
            n_fail++;
            $display("FAIL back_to_back: second=%h, required %h", last_sig, first);
        end
    endtask

    task automatic test_seed0_loopback();
        exp_t e;
        int   c;
        sif.golden_sig = 16'h0004;
        e.sig  = model_sig(16'h0000, 2, 2);
        e.pass = 1'b0;
        exp_q.push_back(e);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        c = 0;
        while (sif.done !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        e = exp_q.pop_front();
        n_chk++;
        if (sif.done !== 1'b1 || sif.signature !== e.sig || sif.pass !== e.pass) begin
            n_fail++;
            $display("FAIL seed0_loopback: done=%b sig=%h pass=%b, required 1 %h %b",
                     sif.done, sif.signature, sif.pass, e.sig, e.pass);
        end
        n_chk++;
        if (sif.signature !== 16'h0003) begin
            n_fail++;
            $display("FAIL seed0_const: sig=%h, required 0003", sif.signature);
        end
    endtask

    task automatic test_n_in1();
        int bc;
        int c;
        nif.golden_sig = 16'hCF9F;
        exp_q.push_back('{sig: model_sig(16'hFFFF, 1, 0), pass: 1'b1});
        nif.start = 1'b1;
        tick();
        nif.start = 1'b0;
        bc = 0;
        c = 0;
        while (nif.done !== 1'b1 && c < 40) begin
            if (nif.busy === 1'b1) bc++;
            tick();
            c++;
        end
        n_chk++;
        if (bc != 3) begin
            n_fail++;
            $display("FAIL n_in1_busy: got %0d, required 3", bc);
        end
        n_chk++;
        if (nif.signature !== 16'hCF9F || nif.pass !== exp_q[0].pass ||
            nif.signature !== exp_q[0].sig) begin
            n_fail++;
            $display("FAIL n_in1_result: sig=%h pass=%b, required cf9f 1", nif.signature, nif.pass);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_zero_resp();
        test_pattern();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_seed0_loopback();
        test_n_in1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
